hazard_stall_ctrl: RTL and testbench

//  Hazard and stall controller for the 5-stage MIPS pipeline. Each cycle it decides whether the ID/EXE register

---
 rtl/hazard_stall_ctrl.sv | 177 +++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hazard_stall_ctrl
// Brief   : Load-use bubble, memory-wait freeze and operand forwarding control
//           for the 5-stage MIPS pipeline, with a saturating stall-cycle count.
// Revision: 1.0  initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [4:0]       edestReg,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic [4:0]       mdestReg,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idexe_bubble,
    output logic             pipe_freeze,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int                c_WC_W      = $clog2(MAX_WAIT + 1);
    localparam logic [c_WC_W-1:0] c_WAIT_MAX  = c_WC_W'(MAX_WAIT);
    localparam logic [c_WC_W-1:0] c_WAIT_ONE  = c_WC_W'(1);
    localparam logic [c_WC_W-1:0] c_WAIT_ZERO = '0;
    localparam logic [CNT_W-1:0]  c_CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  c_CNT_ONE   = CNT_W'(1);

    localparam logic [0:0] c_ST_RUN    = 1'b0;
    localparam logic [0:0] c_ST_FREEZE = 1'b1;

    localparam logic [1:0] c_FWD_RF   = 2'b00;
    localparam logic [1:0] c_FWD_EALU = 2'b01;
    localparam logic [1:0] c_FWD_MALU = 2'b10;
    localparam logic [1:0] c_FWD_MLD  = 2'b11;

    logic [0:0]        r_st;
    logic [0:0]        w_st_nxt;
    logic [c_WC_W-1:0] r_wait_cnt;
    logic [c_WC_W-1:0] w_wait_nxt;
    logic              r_mem_timeout;
    logic              w_timeout_set;
    logic [CNT_W-1:0]  r_stall_count;

    logic w_hit_e_rs;
    logic w_hit_e_rt;
    logic w_hit_m_rs;
    logic w_hit_m_rt;
    logic w_load_use;
    logic w_mem_wait;

    // Register 0 is hard-wired, so a write to it never creates a dependence.
    assign w_hit_e_rs = ewreg && (edestReg != 5'd0) && (edestReg == id_rs);
    assign w_hit_e_rt = ewreg && (edestReg != 5'd0) && (edestReg == id_rt);
    assign w_hit_m_rs = mwreg && (mdestReg != 5'd0) && (mdestReg == id_rs);
    assign w_hit_m_rt = mwreg && (mdestReg != 5'd0) && (mdestReg == id_rt);

    assign w_load_use = em2reg && ((id_uses_rs && w_hit_e_rs) ||
                                   (id_uses_rt && w_hit_e_rt));
    assign w_mem_wait = mem_req && !dmem_ready;

    function automatic logic [1:0] f_fwd_sel(input logic uses,
                                             input logic hit_e,
                                             input logic hit_m);
        logic [1:0] sel;
        sel = c_FWD_RF;
        if (uses) begin
            if (hit_e && !em2reg) begin
                sel = c_FWD_EALU;
            end else if (hit_m && !mm2reg) begin
                sel = c_FWD_MALU;
            end else if (hit_m && mm2reg) begin
                sel = c_FWD_MLD;
            end
        end
        return sel;
    endfunction

    assign fwda = f_fwd_sel(id_uses_rs, w_hit_e_rs, w_hit_m_rs);
    assign fwdb = f_fwd_sel(id_uses_rt, w_hit_e_rt, w_hit_m_rt);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_st       <= c_ST_RUN;
            r_wait_cnt <= c_WAIT_ZERO;
        end else begin
            r_st       <= w_st_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // A freeze dominates a load-use hazard; the hazard is re-evaluated on the
    // release cycle, which then issues the bubble.
    always_comb begin
        w_st_nxt      = r_st;
        w_wait_nxt    = r_wait_cnt;
        w_timeout_set = 1'b0;
        pc_we         = 1'b1;
        ifid_we       = 1'b1;
        idexe_bubble  = 1'b0;
        pipe_freeze   = 1'b0;
        case (r_st)
            c_ST_RUN: begin
                if (w_mem_wait) begin
                    pipe_freeze = 1'b1;
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    w_st_nxt    = c_ST_FREEZE;
                    w_wait_nxt  = c_WAIT_ONE;
                end else if (w_load_use) begin
                    pc_we        = 1'b0;
                    ifid_we      = 1'b0;
                    idexe_bubble = 1'b1;
                end
            end
            c_ST_FREEZE: begin
                if (w_mem_wait) begin
                    pipe_freeze = 1'b1;
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    if (r_wait_cnt == c_WAIT_MAX) begin
                        w_timeout_set = 1'b1;
                    end else begin
                        w_wait_nxt = r_wait_cnt + c_WAIT_ONE;
                    end
                end else begin
                    w_st_nxt   = c_ST_RUN;
                    w_wait_nxt = c_WAIT_ZERO;
                    if (w_load_use) begin
                        pc_we        = 1'b0;
                        ifid_we      = 1'b0;
                        idexe_bubble = 1'b1;
                    end
                end
            end
            default: begin
                w_st_nxt   = c_ST_RUN;
                w_wait_nxt = c_WAIT_ZERO;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem_timeout <= 1'b0;
        end else if (w_timeout_set) begin
            r_mem_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_count <= '0;
        end else if (!pc_we && (r_stall_count != c_CNT_MAX)) begin
            r_stall_count <= r_stall_count + c_CNT_ONE;
        end
    end

    assign mem_timeout = r_mem_timeout;
    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_stall_ctrl
// Brief   : Directed vector table plus multi-cycle sequences for the hazard
//           and stall controller (MAX_WAIT=4, 4-bit stall counter).
// Revision: 1.0  initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    localparam int c_MAX_WAIT = 4;
    localparam int c_CNT_W    = 4;

    logic               clock = 1'b0;
    logic               reset;
    logic [4:0]         id_rs, id_rt, edestReg, mdestReg;
    logic               id_uses_rs, id_uses_rt;
    logic               ewreg, em2reg, mwreg, mm2reg, mem_req, dmem_ready;
    logic               pc_we, ifid_we, idexe_bubble, pipe_freeze, mem_timeout;
    logic [1:0]         fwda, fwdb;
    logic [c_CNT_W-1:0] stall_count;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_stall_ctrl #(
        .MAX_WAIT(c_MAX_WAIT),
        .CNT_W   (c_CNT_W)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rs  (id_uses_rs),
        .id_uses_rt  (id_uses_rt),
        .ewreg       (ewreg),
        .em2reg      (em2reg),
        .edestReg    (edestReg),
        .mwreg       (mwreg),
        .mm2reg      (mm2reg),
        .mdestReg    (mdestReg),
        .mem_req     (mem_req),
        .dmem_ready  (dmem_ready),
        .pc_we       (pc_we),
        .ifid_we     (ifid_we),
        .idexe_bubble(idexe_bubble),
        .pipe_freeze (pipe_freeze),
        .fwda        (fwda),
        .fwdb        (fwdb),
        .mem_timeout (mem_timeout),
        .stall_count (stall_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0] rs, rt;
        logic       urs, urt, ew, em;
        logic [4:0] ed;
        logic       mw, mm;
        logic [4:0] md;
        logic       mreq, rdy;
        logic       x_pc, x_bub;
        logic [1:0] x_fa, x_fb;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt,
                                input logic ew, input logic em, input logic [4:0] ed,
                                input logic mw, input logic mm, input logic [4:0] md,
                                input logic mreq, input logic rdy,
                                input logic x_pc, input logic x_bub,
                                input logic [1:0] x_fa, input logic [1:0] x_fb);
        vec_t v;
        v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
        v.ew = ew; v.em = em; v.ed = ed;
        v.mw = mw; v.mm = mm; v.md = md;
        v.mreq = mreq; v.rdy = rdy;
        v.x_pc = x_pc; v.x_bub = x_bub; v.x_fa = x_fa; v.x_fb = x_fb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        ewreg = 1'b0; em2reg = 1'b0; edestReg = 5'd0;
        mwreg = 1'b0; mm2reg = 1'b0; mdestReg = 5'd0;
        mem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge clock);
        reset = 1'b1;
        idle();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic set_load_use_rs5();
        ewreg = 1'b1; em2reg = 1'b1; edestReg = 5'd5;
        id_rs = 5'd5; id_uses_rs = 1'b1;
    endtask

    task automatic load_now_in_mem();
        ewreg = 1'b0; em2reg = 1'b0; edestReg = 5'd0;
        mwreg = 1'b1; mm2reg = 1'b1; mdestReg = 5'd5;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rs     rt     urs   urt   ew    em    ed     mw    mm    md     mreq  rdy   pc    bub   fa     fb
        vecs[0]  = mk(5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        vecs[1]  = mk(5'd7,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 5'd7,  1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00);
        vecs[2]  = mk(5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        vecs[3]  = mk(5'd4,  5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 5'd3,  1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10);
        vecs[4]  = mk(5'd9,  5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 5'd9,  1'b0, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00);
        vecs[5]  = mk(5'd1,  5'd12, 1'b1, 1'b1, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        vecs[6]  = mk(5'd1,  5'd12, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);
        vecs[7]  = mk(5'd5,  5'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 5'd5,  1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00);
        vecs[8]  = mk(5'd2,  5'd6,  1'b1, 1'b1, 1'b1, 1'b0, 5'd2,  1'b1, 1'b1, 5'd6,  1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b11);
        vecs[9]  = mk(5'd8,  5'd0,  1'b1, 1'b0, 1'b1, 1'b1, 5'd8,  1'b1, 1'b0, 5'd8,  1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00);
        vecs[10] = mk(5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        vecs[11] = mk(5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00);

        reset = 1'b1;
        idle();
        reset_dut();
        #1;
        chk("reset_pc_we", pc_we, 1'b1);
        chk("reset_freeze", pipe_freeze, 1'b0);
        chk("reset_stall_count", stall_count, 0);
        chk("reset_timeout", mem_timeout, 1'b0);

        // Combinational decode in RUN; only vectors 5 and 9 stall.
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            id_rs = vecs[i].rs; id_rt = vecs[i].rt;
            id_uses_rs = vecs[i].urs; id_uses_rt = vecs[i].urt;
            ewreg = vecs[i].ew; em2reg = vecs[i].em; edestReg = vecs[i].ed;
            mwreg = vecs[i].mw; mm2reg = vecs[i].mm; mdestReg = vecs[i].md;
            mem_req = vecs[i].mreq; dmem_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d_pc_we", i), pc_we, vecs[i].x_pc);
            chk($sformatf("vec%0d_ifid_we", i), ifid_we, vecs[i].x_pc);
            chk($sformatf("vec%0d_bubble", i), idexe_bubble, vecs[i].x_bub);
            chk($sformatf("vec%0d_freeze", i), pipe_freeze, 1'b0);
            chk($sformatf("vec%0d_fwda", i), fwda, vecs[i].x_fa);
            chk($sformatf("vec%0d_fwdb", i), fwdb, vecs[i].x_fb);
        end
        @(negedge clock);
        idle();
        #1;
        chk("table_stall_count", stall_count, 2);

        // T1: single load-use bubble, then forward from MEM load data
        reset_dut();
        set_load_use_rs5();
        #1;
        chk("t1_pc_we", pc_we, 1'b0);
        chk("t1_bubble", idexe_bubble, 1'b1);
        @(negedge clock);
        load_now_in_mem();
        #1;
        chk("t1_fwda_load", fwda, 2'b11);
        chk("t1_pc_we_after", pc_we, 1'b1);
        chk("t1_bubble_after", idexe_bubble, 1'b0);
        chk("t1_stall_count", stall_count, 1);

        // T3: three not-ready cycles, released on the fourth
        reset_dut();
        mem_req = 1'b1; dmem_ready = 1'b0;
        #1;
        chk("t3_freeze0", pipe_freeze, 1'b1);
        chk("t3_pc_we0", pc_we, 1'b0);
        for (int i = 1; i < 3; i++) begin
            @(negedge clock);
            #1;
            chk($sformatf("t3_freeze%0d", i), pipe_freeze, 1'b1);
            chk($sformatf("t3_stall%0d", i), stall_count, i);
        end
        @(negedge clock);
        dmem_ready = 1'b1;
        #1;
        chk("t3_release_freeze", pipe_freeze, 1'b0);
        chk("t3_release_pc_we", pc_we, 1'b1);
        chk("t3_release_stall", stall_count, 3);
        @(negedge clock);
        idle();
        #1;
        chk("t3_after_stall", stall_count, 3);
        chk("t3_after_pc_we", pc_we, 1'b1);

        // T4: timeout after 4th FREEZE cycle; counter saturates at 15
        reset_dut();
        mem_req = 1'b1; dmem_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clock);
            #1;
            if (k <= 6) chk($sformatf("t4_timeout_c%0d", k), mem_timeout, (k >= 5) ? 1'b1 : 1'b0);
            chk($sformatf("t4_freeze_c%0d", k), pipe_freeze, 1'b1);
            chk($sformatf("t4_stall_c%0d", k), stall_count, (k > 15) ? 15 : k);
        end

        // T6: reset in FREEZE aborts the freeze and clears counters
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        mem_req = 1'b0;
        #1;
        chk("t6_pc_we", pc_we, 1'b1);
        chk("t6_freeze", pipe_freeze, 1'b0);
        chk("t6_stall_count", stall_count, 0);
        chk("t6_timeout", mem_timeout, 1'b0);

        // T5: freeze dominates load_use; bubble issued on release cycle
        reset_dut();
        set_load_use_rs5();
        mem_req = 1'b1; dmem_ready = 1'b0;
        #1;
        chk("t5_freeze0", pipe_freeze, 1'b1);
        chk("t5_bubble0", idexe_bubble, 1'b0);
        chk("t5_pc_we0", pc_we, 1'b0);
        @(negedge clock);
        #1;
        chk("t5_freeze1", pipe_freeze, 1'b1);
        chk("t5_bubble1", idexe_bubble, 1'b0);
        @(negedge clock);
        dmem_ready = 1'b1;
        #1;
        chk("t5_release_freeze", pipe_freeze, 1'b0);
        chk("t5_release_bubble", idexe_bubble, 1'b1);
        chk("t5_release_pc_we", pc_we, 1'b0);
        @(negedge clock);
        idle();
        load_now_in_mem();
        id_rs = 5'd5; id_uses_rs = 1'b1;
        #1;
        chk("t5_fwda_load", fwda, 2'b11);
        chk("t5_pc_we_after", pc_we, 1'b1);
        chk("t5_stall_count", stall_count, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
